// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/redirect controller for the 5-stage RV64 pipeline
module pipeline_ctrl #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall_req,
    input  logic             id_stall_req,
    input  logic             id_flush,
    input  logic             mem_stall_req,
    input  logic             ex_trap_req,
    input  logic             ex_mret_req,
    input  logic [PC_W-1:0]  mtvec_i,
    input  logic [PC_W-1:0]  mepc_i,
    output logic [4:0]       stall_o,
    output logic [4:0]       flush_o,
    output logic             redirect_ena_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             trap_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] stall_cnt;
    logic [4:0]       stall;
    logic [4:0]       flush;
    logic             trap_any;

    assign trap_any = ex_trap_req | ex_mret_req;

    // Held low during reset so every output reads zero without a clock edge.
    always_comb begin
        stall = 5'b00000;
        flush = 5'b00000;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_stall_req) begin
                        stall = 5'b01111;
                        flush = 5'b10000;
                    end else if (trap_any) begin
                        stall = 5'b00001;
                        flush = 5'b00110;
                    end else if (id_stall_req) begin
                        stall = 5'b00011;
                        flush = 5'b00100;
                    end else if (id_flush) begin
                        flush = 5'b00010;
                    end else if (if_stall_req) begin
                        stall = 5'b00001;
                        flush = 5'b00010;
                    end
                end
                DRAIN: begin
                    if (mem_stall_req) begin
                        stall = 5'b01111;
                        flush = 5'b10000;
                    end else begin
                        stall = 5'b00001;
                        flush = 5'b00110;
                    end
                end
                REDIRECT: begin
                    flush = 5'b00110;
                end
                default: begin
                    stall = 5'b00000;
                    flush = 5'b00000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The target is captured even when a mem stall defers the accept.
                    if (trap_any) begin
                        target <= ex_trap_req ? mtvec_i : mepc_i;
                        state  <= mem_stall_req ? DRAIN : REDIRECT;
                    end
                end
                DRAIN: begin
                    if (!mem_stall_req) begin
                        state <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (!if_stall_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall[0] && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_o        = stall;
    assign flush_o        = flush;
    assign redirect_ena_o = (state == REDIRECT);
    assign redirect_pc_o  = target;
    assign trap_busy_o    = (state != IDLE);
    assign stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        id_flush;
    logic        mem_stall_req;
    logic        ex_trap_req;
    logic        ex_mret_req;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        redirect_ena_o;
    logic [63:0] redirect_pc_o;
    logic        trap_busy_o;
    logic [3:0]  stall_cnt_o;

    int vectors;
    int miscompares;

    pipeline_ctrl #(.PC_W(64), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall_req   (if_stall_req),
        .id_stall_req   (id_stall_req),
        .id_flush       (id_flush),
        .mem_stall_req  (mem_stall_req),
        .ex_trap_req    (ex_trap_req),
        .ex_mret_req    (ex_mret_req),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .redirect_ena_o (redirect_ena_o),
        .redirect_pc_o  (redirect_pc_o),
        .trap_busy_o    (trap_busy_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        if_stall_req  = 1'b0;
        id_stall_req  = 1'b0;
        id_flush      = 1'b0;
        mem_stall_req = 1'b0;
        ex_trap_req   = 1'b0;
        ex_mret_req   = 1'b0;
        mtvec_i       = 64'h0;
        mepc_i        = 64'h0;

        #2;
        chk("rst_stall", stall_o, 5'b00000);
        chk("rst_flush", flush_o, 5'b00000);
        chk("rst_redir", redirect_ena_o, 1'b0);
        chk("rst_busy", trap_busy_o, 1'b0);
        chk("rst_cnt", stall_cnt_o, 4'd0);
        chk("rst_pc", redirect_pc_o, 64'h0);
        step();
        rst = 1'b0;

        // load-use
        id_stall_req = 1'b1;
        #1;
        chk("lu_stall", stall_o, 5'b00011);
        chk("lu_flush", flush_o, 5'b00100);
        step();
        id_stall_req = 1'b0;
        #1;
        chk("lu_stall_after", stall_o, 5'b00000);
        chk("lu_flush_after", flush_o, 5'b00000);
        chk("lu_cnt", stall_cnt_o, 4'd1);

        // jalr flush
        id_flush = 1'b1;
        #1;
        chk("jf_stall", stall_o, 5'b00000);
        chk("jf_flush", flush_o, 5'b00010);
        step();
        id_flush = 1'b0;

        // priority: mem stall beats id and if stalls
        mem_stall_req = 1'b1;
        id_stall_req  = 1'b1;
        if_stall_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pri_stall", stall_o, 5'b01111);
            chk("pri_flush", flush_o, 5'b10000);
            step();
        end
        mem_stall_req = 1'b0;
        id_stall_req  = 1'b0;
        if_stall_req  = 1'b0;
        #1;
        chk("pri_cnt", stall_cnt_o, 4'd4);
        chk("pri_busy", trap_busy_o, 1'b0);

        // ecall without mem stall
        mtvec_i     = 64'h8000_0100;
        mepc_i      = 64'h8000_0040;
        ex_trap_req = 1'b1;
        #1;
        chk("ec_acc_stall", stall_o, 5'b00001);
        chk("ec_acc_flush", flush_o, 5'b00110);
        chk("ec_acc_redir", redirect_ena_o, 1'b0);
        step();
        ex_trap_req  = 1'b0;
        id_stall_req = 1'b1;
        #1;
        chk("ec_redir", redirect_ena_o, 1'b1);
        chk("ec_pc", redirect_pc_o, 64'h8000_0100);
        chk("ec_busy", trap_busy_o, 1'b1);
        chk("ec_redir_stall", stall_o, 5'b00000);
        chk("ec_redir_flush", flush_o, 5'b00110);
        step();
        id_stall_req = 1'b0;
        #1;
        chk("ec_idle_busy", trap_busy_o, 1'b0);
        chk("ec_idle_redir", redirect_ena_o, 1'b0);
        chk("ec_cnt", stall_cnt_o, 4'd5);

        // ecall and mret together: trap vector wins
        ex_trap_req = 1'b1;
        ex_mret_req = 1'b1;
        step();
        ex_trap_req = 1'b0;
        ex_mret_req = 1'b0;
        #1;
        chk("both_redir", redirect_ena_o, 1'b1);
        chk("both_pc", redirect_pc_o, 64'h8000_0100);
        step();

        // mret during a 4-cycle mem stall
        mem_stall_req = 1'b1;
        ex_mret_req   = 1'b1;
        #1;
        chk("mr_c1_stall", stall_o, 5'b01111);
        chk("mr_c1_flush", flush_o, 5'b10000);
        step();
        ex_mret_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mr_drain_busy", trap_busy_o, 1'b1);
            chk("mr_drain_stall", stall_o, 5'b01111);
            chk("mr_drain_redir", redirect_ena_o, 1'b0);
            step();
        end
        mem_stall_req = 1'b0;
        if_stall_req  = 1'b1;
        #1;
        chk("mr_exit_stall", stall_o, 5'b00001);
        chk("mr_exit_flush", flush_o, 5'b00110);
        chk("mr_exit_redir", redirect_ena_o, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("mr_hold_redir", redirect_ena_o, 1'b1);
            chk("mr_hold_pc", redirect_pc_o, 64'h8000_0040);
            chk("mr_hold_stall", stall_o, 5'b00000);
            step();
        end
        if_stall_req = 1'b0;
        #1;
        chk("mr_last_redir", redirect_ena_o, 1'b1);
        chk("mr_last_pc", redirect_pc_o, 64'h8000_0040);
        step();
        chk("mr_done_busy", trap_busy_o, 1'b0);
        chk("mr_done_redir", redirect_ena_o, 1'b0);
        chk("mr_cnt", stall_cnt_o, 4'd11);

        // asynchronous reset while in REDIRECT
        ex_trap_req = 1'b1;
        step();
        ex_trap_req = 1'b0;
        #1;
        chk("ar_pre_redir", redirect_ena_o, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_busy", trap_busy_o, 1'b0);
        chk("ar_redir", redirect_ena_o, 1'b0);
        chk("ar_cnt", stall_cnt_o, 4'd0);
        chk("ar_pc", redirect_pc_o, 64'h0);
        step();
        rst = 1'b0;

        // counter saturation
        if_stall_req = 1'b1;
        #1;
        chk("sat_stall", stall_o, 5'b00001);
        chk("sat_flush", flush_o, 5'b00010);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) chk("sat_cnt14", stall_cnt_o, 4'd14);
        end
        chk("sat_cnt", stall_cnt_o, 4'hF);
        if_stall_req = 1'b0;
        step();
        chk("sat_hold", stall_cnt_o, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
